// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : RV32I multi-cycle sequencer (FETCH/DECODE/EXECUTE/MEMORY/
//               WRITEBACK) with retired-instruction counter.
//               Optional macro ILLEGAL_TRAP_EN: unknown opcodes enter TRAP.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [4:0]          rd,
    input  logic                branch_taken,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                ir_write,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                reg_write,
    output logic                pc_write,
    output logic [1:0]          pc_sel,
    output logic                alu_src_imm,
    output logic [2:0]          alu_funct3,
    output logic [1:0]          wb_sel,
    output logic [2:0]          state,
    output logic [BITWIDTH-1:0] instret,
    output logic                illegal_instr
);

    localparam logic [2:0] C_ST_FETCH     = 3'd0;
    localparam logic [2:0] C_ST_DECODE    = 3'd1;
    localparam logic [2:0] C_ST_EXECUTE   = 3'd2;
    localparam logic [2:0] C_ST_MEMORY    = 3'd3;
    localparam logic [2:0] C_ST_WRITEBACK = 3'd4;
    localparam logic [2:0] C_ST_TRAP      = 3'd5;

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_OP     = 7'b0110011;
    localparam logic [6:0] C_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;

    logic [2:0]          state_q, state_d;
    logic [BITWIDTH-1:0] instret_q, instret_d;

    logic w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr;
    logic w_uses_imm, w_known, w_retire;

    always_comb begin
        w_is_load   = (opcode == C_OP_LOAD);
        w_is_store  = (opcode == C_OP_STORE);
        w_is_branch = (opcode == C_OP_BRANCH);
        w_is_jal    = (opcode == C_OP_JAL);
        w_is_jalr   = (opcode == C_OP_JALR);
        w_uses_imm  = (opcode == C_OP_OPIMM) || w_is_load || w_is_store ||
                      w_is_jalr || (opcode == C_OP_LUI) || (opcode == C_OP_AUIPC);
        w_known     = w_uses_imm || w_is_branch || w_is_jal || (opcode == C_OP_OP);
    end

    // One retirement per instruction: branch in EXECUTE, store in MEMORY,
    // everything else in WRITEBACK.
    always_comb begin
        w_retire = ((state_q == C_ST_EXECUTE) && w_is_branch) ||
                   ((state_q == C_ST_MEMORY) && w_is_store && dmem_ready) ||
                   (state_q == C_ST_WRITEBACK);
        instret_d = instret_q + {{(BITWIDTH-1){1'b0}}, w_retire};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= C_ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_FETCH: begin
                if (imem_ready) state_d = C_ST_DECODE;
            end
            C_ST_DECODE: state_d = C_ST_EXECUTE;
            C_ST_EXECUTE: begin
                if (w_is_branch) begin
                    state_d = C_ST_FETCH;
                end else if (w_is_load || w_is_store) begin
                    state_d = C_ST_MEMORY;
                end else if (w_known) begin
                    state_d = C_ST_WRITEBACK;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = C_ST_TRAP;
`else
                    state_d = C_ST_WRITEBACK;
`endif
                end
            end
            C_ST_MEMORY: begin
                if (dmem_ready) state_d = w_is_store ? C_ST_FETCH : C_ST_WRITEBACK;
            end
            C_ST_WRITEBACK: state_d = C_ST_FETCH;
            C_ST_TRAP:      state_d = C_ST_TRAP;
            default:        state_d = C_ST_FETCH;
        endcase
    end

    // Output logic; everything is held low while reset is asserted.
    always_comb begin
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_write   = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 2'd0;
        alu_src_imm = 1'b0;
        alu_funct3  = 3'd0;
        wb_sel      = 2'd0;
        if (rst_n) begin
            case (state_q)
                C_ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                C_ST_EXECUTE: begin
                    alu_funct3  = funct3;
                    alu_src_imm = w_uses_imm;
                    if (w_is_branch) begin
                        pc_write = 1'b1;
                        pc_sel   = branch_taken ? 2'd1 : 2'd0;
                    end
                end
                C_ST_MEMORY: begin
                    dmem_req = 1'b1;
                    dmem_we  = w_is_store;
                    pc_write = w_is_store && dmem_ready;
                end
                C_ST_WRITEBACK: begin
                    // Unknown opcodes reach here only as NOPs: no register write.
                    reg_write = (rd != 5'd0) && w_known;
                    pc_write  = 1'b1;
                    if (w_is_jal) begin
                        pc_sel = 2'd1;
                        wb_sel = 2'd2;
                    end else if (w_is_jalr) begin
                        pc_sel = 2'd2;
                        wb_sel = 2'd2;
                    end else if (w_is_load) begin
                        wb_sel = 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q || ((state_q == C_ST_EXECUTE) && !w_known);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end

    assign illegal_instr = illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule
`default_nettype wire
